// File: rtl/clk_ctrl_if.sv
// Control/status bundle of the clock-enable generator: divide writes, run mode,
// single-step handshake and the registered tick/phase/heartbeat outputs.
interface clk_ctrl_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CNT_W    = 32
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                div_wr;
  logic [SEL_W-1:0]    div_sel;
  logic [CNT_W-1:0]    div_val;
  logic [1:0]          mode;
  logic                step_req;
  logic                step_ack;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] phase;
  logic                led;
  logic                running;

  modport master (
    output div_wr, div_sel, div_val, mode, step_req,
    input  step_ack, tick, phase, led, running
  );

  modport slave (
    input  div_wr, div_sel, div_val, mode, step_req,
    output step_ack, tick, phase, led, running
  );
endinterface

// File: rtl/clk_ctrl.sv
// Programmable per-channel clock-enable generator with run/halt/single-step
// control and a heartbeat LED derived from channel 0.
module clk_ctrl #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DIV_DEFAULT = 1,
  parameter bit          START_RUN   = 1'b1,
  parameter int unsigned LED_DIV     = 1
) (
  input logic       clk,
  input logic       reset,
  clk_ctrl_if.slave bus
);

  localparam int unsigned      LED_W    = 16;
  localparam logic [LED_W-1:0] LED_LAST = LED_W'(LED_DIV - 1);

  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  localparam logic [2:0] ST_HALT  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_ARM   = 3'd2;
  localparam logic [2:0] ST_FIRE  = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;
  localparam logic [2:0] ST_RESET = START_RUN ? ST_RUN : ST_HALT;

  logic [2:0]                     state_q, state_d;
  logic [CHANNELS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][CNT_W-1:0] div_q, div_d;
  logic [CHANNELS-1:0]            tick_q, tick_d;
  logic [CHANNELS-1:0]            phase_q, phase_d;
  logic                           step_ack_q, step_ack_d;
  logic                           running_q, running_d;
  logic                           led_q, led_d;
  logic [LED_W-1:0]               led_cnt_q, led_cnt_d;

  logic                           fire;
  logic                           in_step;
  logic [CNT_W-1:0]               last;

  // Mode is sampled every cycle except in STEP_FIRE, which always completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT, ST_RUN: begin
        if (bus.mode == MODE_RUN)       state_d = ST_RUN;
        else if (bus.mode == MODE_STEP) state_d = ST_ARM;
        else                            state_d = ST_HALT;
      end
      ST_ARM: begin
        if (bus.mode == MODE_RUN)       state_d = ST_RUN;
        else if (bus.mode == MODE_STEP) state_d = bus.step_req ? ST_FIRE : ST_ARM;
        else                            state_d = ST_HALT;
      end
      ST_FIRE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (bus.mode == MODE_RUN)       state_d = ST_RUN;
        else if (bus.mode == MODE_STEP) state_d = bus.step_req ? ST_HOLD : ST_ARM;
        else                            state_d = ST_HALT;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // The step pulse is registered on the edge that enters STEP_FIRE.
  assign fire       = (state_q == ST_ARM) && (state_d == ST_FIRE);
  assign in_step    = (state_q == ST_ARM) || (state_q == ST_FIRE) || (state_q == ST_HOLD);
  assign step_ack_d = fire;
  assign running_d  = (state_d == ST_RUN);

  always_comb begin
    cnt_d   = cnt_q;
    div_d   = div_q;
    tick_d  = '0;
    phase_d = phase_q;
    last    = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      last = (div_q[i] == '0) ? '0 : div_q[i] - CNT_W'(1);
      if (fire) begin
        tick_d[i]  = 1'b1;
        phase_d[i] = ~phase_q[i];
        cnt_d[i]   = '0;
      end else if (state_q == ST_RUN) begin
        if (cnt_q[i] == last) begin
          cnt_d[i]   = '0;
          tick_d[i]  = 1'b1;
          phase_d[i] = ~phase_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end else if (in_step) begin
        // Leaving a step state for RUN always restarts from a zero count.
        cnt_d[i] = '0;
      end
      // A divide write restarts the channel and suppresses its tick this cycle.
      if (bus.div_wr && (int'(bus.div_sel) == i)) begin
        div_d[i]   = bus.div_val;
        cnt_d[i]   = '0;
        tick_d[i]  = 1'b0;
        phase_d[i] = phase_q[i];
      end
    end
  end

  // Heartbeat: toggle once every LED_DIV channel-0 ticks, step ticks included.
  always_comb begin
    led_cnt_d = led_cnt_q;
    led_d     = led_q;
    if (tick_d[0]) begin
      if (led_cnt_q == LED_LAST) begin
        led_cnt_d = '0;
        led_d     = ~led_q;
      end else begin
        led_cnt_d = led_cnt_q + LED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      cnt_q      <= '0;
      div_q      <= {CHANNELS{CNT_W'(DIV_DEFAULT)}};
      tick_q     <= '0;
      phase_q    <= '0;
      step_ack_q <= 1'b0;
      running_q  <= START_RUN;
      led_q      <= 1'b0;
      led_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      phase_q    <= phase_d;
      step_ack_q <= step_ack_d;
      running_q  <= running_d;
      led_q      <= led_d;
      led_cnt_q  <= led_cnt_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.phase    = phase_q;
  assign bus.step_ack = step_ack_q;
  assign bus.running  = running_q;
  assign bus.led      = led_q;

endmodule

// File: tb/tb_clk_ctrl.sv
// Scoreboard bench for clk_ctrl: each scenario queues expected tick/ack/running per
// cycle; phase and led expectations are accumulated from the expected ticks.
module tb_clk_ctrl;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned CNT_W    = 32;

  typedef struct packed {
    logic [1:0] tick;
    logic       ack;
    logic       running;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  clk_ctrl_if #(.CHANNELS(CHANNELS), .CNT_W(CNT_W)) bus ();

  clk_ctrl #(
    .CHANNELS(CHANNELS), .CNT_W(CNT_W), .DIV_DEFAULT(1), .START_RUN(1'b1), .LED_DIV(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [1:0] exp_phase   = '0;
  logic       exp_led     = 1'b0;
  logic [6:0] got, want;

  task automatic drive(input logic wr, input logic [0:0] sel, input logic [31:0] val,
                       input logic [1:0] md, input logic req);
    bus.div_wr   = wr;
    bus.div_sel  = sel;
    bus.div_val  = val;
    bus.mode     = md;
    bus.step_req = req;
  endtask

  task automatic push(input logic [1:0] t, input logic a, input logic r);
    exp_t e;
    e.tick    = t;
    e.ack     = a;
    e.running = r;
    exp_q.push_back(e);
  endtask

  // One clock: pop the expectation for this edge and sample the DUT just after it.
  task automatic advance(output logic [6:0] g, output logic [6:0] w);
    exp_t e;
    @(posedge clk);
    #1;
    e         = exp_q.pop_front();
    exp_phase = exp_phase ^ e.tick;
    exp_led   = exp_led ^ e.tick[0];
    g = {bus.tick, bus.phase, bus.step_ack, bus.led, bus.running};
    w = {e.tick, exp_phase, e.ack, exp_led, e.running};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 2'b01, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_phase = '0;
    exp_led   = 1'b0;
    got  = {bus.tick, bus.phase, bus.step_ack, bus.led, bus.running};
    vectors++;
    if (got !== 7'b00_00_0_0_1) begin
      miscompares++;
      $display("FAIL reset_state: got %b want %b", got, 7'b00_00_0_0_1);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_default_run();
    for (int k = 0; k < 6; k++) begin
      push(2'b11, 1'b0, 1'b1);
      advance(got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL default_run[%0d]: got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_div_write();
    for (int k = 0; k < 12; k++) begin
      drive(k == 0, 1'b1, 32'd4, 2'b01, 1'b0);
      push({(k > 0) && (k % 4 == 0), 1'b1}, 1'b0, 1'b1);
      advance(got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL div_write[%0d]: got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_div_zero_and_collision();
    for (int k = 0; k < 17; k++) begin
      drive((k == 0) || (k == 4) || (k == 12), 1'b1, (k == 0) ? 32'd0 : 32'd4, 2'b01, 1'b0);
      push({(k == 1) || (k == 2) || (k == 3) || (k == 8) || (k == 16), 1'b1}, 1'b0, 1'b1);
      advance(got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL div_zero_collision[%0d]: got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_halt();
    logic [1:0] md;
    logic [1:0] t;
    for (int k = 0; k < 19; k++) begin
      md = (k < 2 || k >= 13) ? 2'b01 : (k < 8 ? 2'b00 : 2'b11);
      drive(1'b0, 1'b0, 32'd0, md, 1'b0);
      if (k <= 2)                                t = 2'b01;
      else if (k <= 13)                          t = 2'b00;
      else if (k == 14 || k == 18)               t = 2'b11;
      else                                       t = 2'b01;
      push(t, 1'b0, (k < 2) || (k >= 13));
      advance(got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL halt_resume[%0d]: got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_step();
    logic [1:0] md;
    logic       req;
    logic [1:0] t;
    for (int k = 0; k < 17; k++) begin
      md  = (k <= 10) ? 2'b10 : 2'b01;
      req = ((k >= 3) && (k <= 7)) || (k == 10) || (k == 11);
      drive(1'b0, 1'b0, 32'd0, md, req);
      if (k == 0)                  t = 2'b01;
      else if (k == 3 || k == 10)  t = 2'b11;
      else if (k <= 12)            t = 2'b00;
      else if (k == 16)            t = 2'b11;
      else                         t = 2'b01;
      push(t, (k == 3) || (k == 10), k >= 12);
      advance(got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL single_step[%0d]: got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    for (int k = 0; k < 10; k++) begin
      drive(k == 0, 1'b0, 32'd7, 2'b01, 1'b0);
      push({(k % 4 == 3), (k == 7)}, 1'b0, 1'b1);
      advance(got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL ch0_div7[%0d]: got %b want %b", k, got, want);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_phase = '0;
    exp_led   = 1'b0;
    got = {bus.tick, bus.phase, bus.step_ack, bus.led, bus.running};
    vectors++;
    if (got !== 7'b00_00_0_0_1) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", got, 7'b00_00_0_0_1);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(2'b11, 1'b0, 1'b1);
      advance(got, want);
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL post_reset_default[%0d]: got %b want %b", k, got, want);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'd0, 2'b01, 1'b0);
    test_reset();
    test_default_run();
    test_div_write();
    test_div_zero_and_collision();
    test_halt();
    test_step();
    test_reset_mid_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_ctrl.md
Name: clk_ctrl

Overview:
- Programmable clock-enable generator for the XM23 core. Replaces the top-level free-running divider with registered per-channel tick pulses.
- Ticks gate the pipeline registers and pipeline controller (and future fetch/memory stages) from the single fabric clock.
- Adds runtime divide values, run/halt/single-step control for bring-up, and an LED heartbeat.

Parameters:
- CHANNELS, 2, number of independent tick channels (1..8).
- CNT_W, 32, width of the divide and count registers.
- DIV_DEFAULT, 1, divide value loaded into every channel at reset.
- START_RUN, 1, 1 = enter RUN after reset; 0 = enter HALT.
- LED_DIV, 1, number of channel-0 ticks per LED toggle (1..2^16).

Ports:
- clk  in  1  fabric clock (50 MHz).
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- div_wr  in  1  one-cycle write strobe for a divide value.
- div_sel  in  max(1,clog2(CHANNELS))  channel selected by div_wr.
- div_val  in  CNT_W  new divide value.
- mode  in  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT.
- step_req  in  1  single-step request, level, held until step_ack is seen.
- step_ack  out  1  one-cycle pulse, coincident with the step tick.
- tick  out  CHANNELS  one-cycle clock-enable pulse per channel.
- phase  out  CHANNELS  square wave, toggles on every tick of its channel.
- led  out  1  heartbeat.
- running  out  1  high while in RUN.

Behaviour:
- Reset (async assert, sync release):
  - tick=0, phase=0, step_ack=0, led=0, cnt[i]=0, div[i]=DIV_DEFAULT, LED counter=0.
  - State = RUN if START_RUN, else HALT; running follows the state.
  - Reset asserted mid-operation discards everything immediately, including any in-flight step.
- All outputs are registered. No combinational path from any input to any output.
- Effective divide is d = max(div[i],1).
- RUN, per channel, every clk edge:
  - if cnt==d-1: cnt<=0, tick[i]<=1, phase[i] toggles;
  - else cnt<=cnt+1, tick[i]<=0.
  - Tick period is d cycles and phase period is 2d cycles. With d=1, tick is constantly 1 and phase toggles every cycle.
- div_wr:
  - div[div_sel]<=div_val and cnt[div_sel]<=0 in the same edge.
  - tick[div_sel] is 0 that cycle; a write wins over a coincident terminal count.
  - The first new tick is registered d edges after the write edge.
  - div_sel>=CHANNELS: write ignored.
  - Writes are accepted in every state.
- HALT: cnt and phase hold, tick=0. Returning to RUN resumes from the held counts.
- States: HALT, RUN, STEP_ARM, STEP_FIRE, STEP_HOLD.
  - HALT/RUN/STEP_ARM/STEP_HOLD re-evaluate mode every cycle. mode 10 from HALT/RUN enters STEP_ARM.
  - STEP_ARM: on step_req=1, go to STEP_FIRE.
  - STEP_FIRE (exactly 1 cycle):
    - all tick bits =1, step_ack=1, all phase bits toggle, all cnt<=0;
    - always completes even if mode changes;
    - next state STEP_HOLD.
  - STEP_HOLD: wait for step_req=0, then STEP_ARM. Exactly one step per request assertion.
  - Leaving any STEP state for RUN starts counting from cnt=0.
- running=1 only in RUN.
- led toggles once every LED_DIV channel-0 ticks; step ticks count. LED_DIV=1 gives led==phase[0].
- Counters are CNT_W wide. cnt never exceeds d-1, so there is no wrap.

Test Plan:
- Release reset, defaults (CHANNELS=2, DIV_DEFAULT=1, START_RUN=1) -> from first edge tick=2'b11 every cycle, phase toggles each cycle, led==phase[0], running=1.
- div_wr sel=1 val=4 in RUN -> tick[1] pulses every 4th cycle, first on 4th edge after write; phase[1] period 8; channel 0 unchanged; write with sel=2 -> no effect.
- div_val=0 written to ch1 -> tick[1] every cycle (treated as 1); write coincident with ch1 terminal count -> no tick that cycle.
- ch1 d=4, switch mode to HALT when cnt=2 -> tick=0 and phase frozen for 10 cycles; back to RUN -> tick[1] on 2nd edge, period 4 thereafter.
- mode=STEP, step_req held 5 cycles -> exactly one cycle with tick=2'b11 and step_ack=1; release and reassert -> second single pulse; mode changed during STEP_FIRE -> pulse still completes.
- ch0 d=7 running, assert reset mid-count -> tick, phase, led, step_ack drop to 0 immediately; after release div back to DIV_DEFAULT, ticks resume every cycle.
